i2c_codec_responder: RTL

- I2C write-only target that models the audio codec's control port, at the far end of the bus driven by the I2C initializer.
- Recognises its 7-bit device address, ACKs the address byte and two data bytes, and decodes each 3-byte write into a 7-bit register address and 9-bit register data.
- Used as the bus partner in system-level simulation and as an on-chip loopback checker for the initializer.

---
 rtl/i2c_pkg.sv | 10 +
 rtl/i2c_bus_sync.sv | 39 +++
 rtl/i2c_codec_responder.sv | 119 +++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// i2c_pkg: shared FSM states, codec device address and register field widths for the I2C codec blocks.
`timescale 1ns/1ps
package i2c_pkg;
  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ACK_A, S_DATA0, S_ACK_0, S_DATA1, S_ACK_1, S_DONE, S_IGNORE
  } state_t;
  localparam logic [6:0] CODEC_ADDR = 7'b0011010;
  localparam int REG_AW = 7;
  localparam int REG_DW = 9;
endpackage

// File: rtl/i2c_bus_sync.sv
// i2c_bus_sync: SCL/SDA synchronizer with START, STOP, SCL-rise and SCL-fall pulses.
`timescale 1ns/1ps
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_sclk,
  input  logic i_sdat,
  output logic o_sda,
  output logic o_start,
  output logic o_stop,
  output logic o_scl_rise,
  output logic o_scl_fall
);
  logic [SYNC_STAGES-1:0] r_scl_sync, r_sda_sync;
  logic r_scl_d, r_sda_d;
  logic w_scl, w_sda;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i_sclk};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i_sdat};
      r_scl_d    <= w_scl;
      r_sda_d    <= w_sda;
    end
  end
  assign w_scl      = r_scl_sync[SYNC_STAGES-1];
  assign w_sda      = r_sda_sync[SYNC_STAGES-1];
  assign o_sda      = w_sda;
  assign o_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
  assign o_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;
  assign o_scl_rise = w_scl & ~r_scl_d;
  assign o_scl_fall = ~w_scl & r_scl_d;
endmodule

// File: rtl/i2c_codec_responder.sv
// i2c_codec_responder: write-only I2C target decoding 3-byte codec register writes.
// Define I2C_RESP_SHADOW_EN to add a 16 x 9-bit shadow register file with a read port.
`timescale 1ns/1ps
module i2c_codec_responder
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = CODEC_ADDR,
  parameter int         SYNC_STAGES = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_sclk,
  input  logic              i_sdat,
`ifdef I2C_RESP_SHADOW_EN
  input  logic [3:0]        i_rd_addr,
  output logic [REG_DW-1:0] o_rd_data,
`endif
  output logic              o_sda_pull,
  output logic              o_wr_valid,
  output logic [REG_AW-1:0] o_reg_addr,
  output logic [REG_DW-1:0] o_reg_data,
  output logic [7:0]        o_wr_count,
  output logic              o_err
);
  logic w_sda, w_start, w_stop, w_rise, w_fall;
  state_t r_state;
  logic [2:0] r_bit_cnt;
  logic r_full, r_pull, r_valid, r_err;
  logic [7:0] r_shift, r_byte0, r_cnt;
  logic [REG_AW-1:0] r_addr;
  logic [REG_DW-1:0] r_data;

  i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_sclk(i_sclk), .i_sdat(i_sdat),
    .o_sda(w_sda), .o_start(w_start), .o_stop(w_stop),
    .o_scl_rise(w_rise), .o_scl_fall(w_fall)
  );

  // A completed byte is judged on the SCL fall after its bit 7, which is also when ACK is driven.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_bit_cnt <= '0;
      r_full    <= 1'b0;
      r_pull    <= 1'b0;
      r_valid   <= 1'b0;
      r_err     <= 1'b0;
      r_shift   <= '0;
      r_byte0   <= '0;
      r_cnt     <= '0;
      r_addr    <= '0;
      r_data    <= '0;
    end else begin
      r_valid <= 1'b0;
      if (w_start) begin
        r_state   <= S_ADDR;
        r_bit_cnt <= '0;
        r_full    <= 1'b0;
        r_pull    <= 1'b0;
        r_err     <= 1'b0;
      end else if (w_stop) begin
        if (r_state inside {S_ADDR, S_ACK_A, S_DATA0, S_ACK_0, S_DATA1, S_ACK_1}) r_err <= 1'b1;
        r_state <= S_IDLE;
        r_pull  <= 1'b0;
        r_full  <= 1'b0;
      end else if (w_rise && r_state inside {S_ADDR, S_DATA0, S_DATA1, S_DONE}) begin
        r_shift   <= {r_shift[6:0], w_sda};
        r_bit_cnt <= r_bit_cnt + 3'd1;
        r_full    <= (r_bit_cnt == 3'd7);
      end else if (w_fall && r_full) begin
        r_full <= 1'b0;
        case (r_state)
          S_ADDR: begin
            r_state <= (r_shift == {DEV_ADDR, 1'b0}) ? S_ACK_A : S_IGNORE;
            r_pull  <= (r_shift == {DEV_ADDR, 1'b0});
            if (r_shift == {DEV_ADDR, 1'b1}) r_err <= 1'b1;
          end
          S_DATA0: begin
            r_state <= S_ACK_0;
            r_pull  <= 1'b1;
            r_byte0 <= r_shift;
          end
          S_DATA1: begin
            r_state <= S_ACK_1;
            r_pull  <= 1'b1;
            r_valid <= 1'b1;
            r_addr  <= r_byte0[7:1];
            r_data  <= {r_byte0[0], r_shift};
            r_cnt   <= r_cnt + 8'd1;
          end
          default: r_err <= 1'b1;
        endcase
      end else if (w_fall && r_state inside {S_ACK_A, S_ACK_0, S_ACK_1}) begin
        r_pull    <= 1'b0;
        r_bit_cnt <= '0;
        r_state   <= (r_state == S_ACK_A) ? S_DATA0 : (r_state == S_ACK_0) ? S_DATA1 : S_DONE;
      end
    end
  end

`ifdef I2C_RESP_SHADOW_EN
  logic [REG_DW-1:0] r_shadow [16];
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 16; i++) r_shadow[i] <= '0;
    end else if (r_valid && r_addr < 7'd16) begin
      r_shadow[r_addr[3:0]] <= r_data;
    end
  end
  assign o_rd_data = r_shadow[i_rd_addr];
`endif

  assign o_sda_pull = r_pull;
  assign o_wr_valid = r_valid;
  assign o_reg_addr = r_addr;
  assign o_reg_data = r_data;
  assign o_wr_count = r_cnt;
  assign o_err      = r_err;
endmodule
